// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the dmem_dma block-transfer initiator.
package dmem_dma_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned CNT_W      = 7;
   localparam int unsigned WORD_BYTES = 4;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

endpackage : dmem_dma_pkg

// File: rtl/dmem_dma.sv
// dmem_dma: word-granular COPY / FILL initiator driving the data-memory port.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, mode         request pulse (sampled in IDLE), 0 = COPY / 1 = FILL
//   src, dst, count     word-aligned byte addresses and word count
//   fill                FILL pattern
//   busy, done, err     status: active, completion pulse, rejection pulse
//   mem_we, mem_a,      memory write enable, byte address, write data
//   mem_wd, mem_rd      and combinational read data
module dmem_dma
   import dmem_dma_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [CNT_W-1:0]  count,
   input  logic [DATA_W-1:0] fill,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   state_t             state;
   logic               mode_q;
   logic [ADDR_W-1:0]  src_ptr;
   logic [ADDR_W-1:0]  dst_ptr;
   logic [CNT_W-1:0]   remaining;

   // FSM with registered outputs: each branch loads the outputs for the state it enters.
   // mem_wd doubles as the word buffer: RD captures mem_rd straight into it for the
   // following WR, and in FILL it holds the pattern for the whole run.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= MODE_COPY;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_a     <= '0;
         mem_wd    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  src_ptr   <= src;
                  dst_ptr   <= dst;
                  remaining <= count;
                  busy      <= 1'b1;
                  // src alignment only matters when it is actually read
                  if ((dst[1:0] != 2'b00) || ((mode == MODE_COPY) && (src[1:0] != 2'b00))) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else if (count == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (mode == MODE_COPY) begin
                     state <= RD;
                     mem_a <= src;
                  end else begin
                     state  <= WR;
                     mem_we <= 1'b1;
                     mem_a  <= dst;
                     mem_wd <= fill;
                  end
               end
            end

            RD: begin
               state  <= WR;
               mem_we <= 1'b1;
               mem_a  <= dst_ptr;
               mem_wd <= mem_rd;
            end

            WR: begin
               src_ptr   <= src_ptr + ADDR_W'(WORD_BYTES);
               dst_ptr   <= dst_ptr + ADDR_W'(WORD_BYTES);
               remaining <= remaining - CNT_W'(1);
               if (remaining > CNT_W'(1)) begin
                  if (mode_q == MODE_COPY) begin
                     state  <= RD;
                     mem_we <= 1'b0;
                     mem_a  <= src_ptr + ADDR_W'(WORD_BYTES);
                     mem_wd <= '0;
                  end else begin
                     mem_a <= dst_ptr + ADDR_W'(WORD_BYTES);
                  end
               end else begin
                  state  <= DONE;
                  done   <= 1'b1;
                  mem_we <= 1'b0;
                  mem_a  <= '0;
                  mem_wd <= '0;
               end
            end

            DONE, ERR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_we <= 1'b0;
               mem_a  <= '0;
               mem_wd <= '0;
            end
         endcase
      end
   end

endmodule : dmem_dma

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: 64-word data memory, directed test-plan steps,
// then randomized operations checked against a word-array reference model.
module tb_dmem_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic [31:0] src;
   logic [31:0] dst;
   logic [6:0]  count;
   logic [31:0] fill;
   logic        busy;
   logic        done;
   logic        err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   // data memory (not reset), plus a bench-side preload port
   logic [31:0] ram [64];
   logic [31:0] mdl [64];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_data;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   dmem_dma dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mode   (mode),
      .src    (src),
      .dst    (dst),
      .count  (count),
      .fill   (fill),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .mem_we (mem_we),
      .mem_a  (mem_a),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   assign mem_rd = ram[mem_a[7:2]];

   always @(posedge clk) begin
      if (pre_we)      ram[pre_idx]    <= pre_data;
      else if (mem_we) ram[mem_a[7:2]] <= mem_wd;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input logic [31:0] a);
      return int'(a[7:2]);
   endfunction

   task automatic preload(input int i, input logic [31:0] v);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 6'(i); pre_data = v;
      @(negedge clk);
      pre_we = 1'b0;
      mdl[i] = v;
   endtask

   task automatic check_mem(input string tag);
      int mism = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== mdl[i]) mism++;
      check(tag, 64'(mism), 64'd0);
   endtask

   // Reference behaviour: word-by-word ascending, so overlap falls out naturally.
   task automatic model_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input int n, input logic [31:0] f,
                           output int e_done, output int e_err, output int e_we, output int e_busy);
      if (d[1:0] != 2'b00 || (m == 1'b0 && s[1:0] != 2'b00)) begin
         e_done = -1; e_err = 1; e_we = 0; e_busy = 1;
      end else begin
         for (int i = 0; i < n; i++) begin
            if (m) mdl[idx(d + 32'(4 * i))] = f;
            else   mdl[idx(d + 32'(4 * i))] = mdl[idx(s + 32'(4 * i))];
         end
         e_err  = -1;
         e_we   = n;
         e_done = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
         e_busy = e_done;
      end
   endtask

   // Issue one request and observe per-cycle status until busy drops.
   task automatic run_op(input string tag, input logic m, input logic [31:0] s,
                         input logic [31:0] d, input int n, input logic [31:0] f, input bit poke);
      int e_done, e_err, e_we, e_busy;
      int done_cyc = -1, err_cyc = -1, we_cnt = 0, busy_cnt = 0;
      bit finished = 1'b0;
      model_op(m, s, d, n, f, e_done, e_err, e_we, e_busy);
      @(negedge clk);
      start = 1'b1; mode = m; src = s; dst = d; count = 7'(n); fill = f;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
         @(negedge clk);
         if (!busy) finished = 1'b1;
         else begin
            busy_cnt++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (err && err_cyc < 0)   err_cyc  = cyc;
            if (mem_we)               we_cnt++;
         end
         // a start while busy must be ignored, not queued
         start = poke && (cyc == 2);
      end
      start = 1'b0;
      check({tag, " finished"}, 64'(finished), 64'd1);
      check({tag, " done cycle"}, 64'(done_cyc), 64'(e_done));
      check({tag, " err cycle"}, 64'(err_cyc), 64'(e_err));
      check({tag, " writes"}, 64'(we_cnt), 64'(e_we));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e_busy));
      check_mem({tag, " memory"});
   endtask

   initial begin
      logic [31:0] rs, rd, rf;
      int          rn;
      logic        rm;
      bit          saw_bad;

      reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; count = '0; fill = '0;
      pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset status", 64'({busy, done, err, mem_we}), 64'd0);
      check("reset mem_a", 64'(mem_a), 64'd0);
      check("reset mem_wd", 64'(mem_wd), 64'd0);

      for (int i = 0; i < 64; i++) preload(i, $urandom);

      // COPY three words 0x00 -> 0x40
      preload(0, 32'h1111_1111);
      preload(1, 32'h2222_2222);
      preload(2, 32'h3333_3333);
      run_op("copy3", 1'b0, 32'h00, 32'h40, 3, 32'h0, 1'b0);
      check("copy3 ram18", 64'(ram[18]), 64'h3333_3333);

      // FILL four words at 0x80, neighbours untouched
      run_op("fill4", 1'b1, 32'h0, 32'h80, 4, 32'hDEAD_BEEF, 1'b0);
      check("fill4 ram35", 64'(ram[35]), 64'hDEAD_BEEF);
      check("fill4 ram31", 64'(ram[31]), 64'(mdl[31]));
      check("fill4 ram36", 64'(ram[36]), 64'(mdl[36]));

      run_op("count0", 1'b0, 32'h00, 32'h40, 0, 32'h0, 1'b0);
      run_op("badsrc", 1'b0, 32'h02, 32'h40, 2, 32'h0, 1'b0);
      run_op("baddst", 1'b1, 32'h00, 32'h41, 2, 32'h5, 1'b0);
      run_op("fillsrc", 1'b1, 32'h02, 32'h00, 1, 32'hCAFE_F00D, 1'b0);

      // overlapping ascending COPY propagates word 0 forward
      preload(0, 32'hA5A5_A5A5);
      run_op("overlap", 1'b0, 32'h00, 32'h04, 3, 32'h0, 1'b1);
      check("overlap ram3", 64'(ram[3]), 64'hA5A5_A5A5);

      // randomized operations, including wrap, overlap and misalignment
      for (int t = 0; t < 30; t++) begin
         rm = 1'($urandom_range(0, 1));
         rs = $urandom;
         rd = ($urandom_range(0, 2) == 0) ? rs + 32'(4 * $urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 4) != 0) begin
            rs[1:0] = 2'b00;
            rd[1:0] = 2'b00;
         end
         rn = $urandom_range(0, 12);
         rf = $urandom;
         run_op($sformatf("rand%0d", t), rm, rs, rd, rn, rf, 1'($urandom_range(0, 1)));
      end

      // reset in cycle 3 of an 8-word FILL: three writes commit, then abandon
      @(negedge clk);
      start = 1'b1; mode = 1'b1; src = '0; dst = '0; count = 7'd8; fill = 32'h5A5A_0F0F;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) mdl[i] = 32'h5A5A_0F0F;
      @(negedge clk);
      check("rst4 status", 64'({busy, done, err, mem_we}), 64'd0);
      check("rst4 mem_a", 64'(mem_a), 64'd0);
      check("rst4 mem_wd", 64'(mem_wd), 64'd0);
      saw_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || err || mem_we || busy) saw_bad = 1'b1;
      end
      check("rst quiet", 64'(saw_bad), 64'd0);
      check_mem("rst memory");
      run_op("postrst", 1'b1, 32'h0, 32'h10, 2, 32'h1234_5678, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_dmem_dma

// File: doc/dmem_dma.md
# dmem_dma

Word-granular memory initiator that drives the data-memory write/read port on behalf of a control master such as a testbench, boot logic or a future coprocessor. It performs block COPY (read source word, write destination word) and block FILL (write a constant pattern) over word-aligned byte addresses. It sits in front of the data memory in place of the CPU datapath's memory port, with one memory access per cycle.

## Interface
- DATA_W, 32, memory word width
- ADDR_W, 32, byte-address width
- CNT_W, 7, width of the word count (0..64 words covers the full 64-word memory)

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = COPY, 1 = FILL
- src  in  ADDR_W  source byte address (COPY only)
- dst  in  ADDR_W  destination byte address
- count  in  CNT_W  number of words
- fill  in  DATA_W  FILL pattern
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse
- mem_we  out  1  memory write enable
- mem_a  out  ADDR_W  memory byte address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data; combinational from mem_a, same cycle

## Operation
- States: IDLE, RD, WR, DONE, ERR.
- IDLE: mem_we=0, mem_a=0, mem_wd=0. When start=1, the block latches mode, src, dst, count and fill.
- Rejection: if dst[1:0]!=0, or mode=COPY and src[1:0]!=0, go to ERR. ERR asserts err for one cycle, then returns to IDLE. No memory access occurs.
- count=0, accepted: go to DONE directly. No access occurs.
- COPY, per word:
  - RD: mem_a=src_ptr, mem_we=0. mem_rd is captured into buf at the edge.
  - WR: mem_a=dst_ptr, mem_we=1, mem_wd=buf. At the edge: src_ptr+=4, dst_ptr+=4, remaining-=1. Go to RD if remaining>1 before the decrement, else go to DONE.
- FILL: stays in WR each cycle with mem_wd=fill. dst_ptr and remaining update as in COPY.
- DONE: done=1 for one cycle, then IDLE.
- Pointer arithmetic is modulo 2^ADDR_W; wrap is silent. There is no range check, because the memory decodes only its low index bits.
- Overlap: COPY is strictly ascending, and each RD observes all earlier WRs. With dst=src+4, the first word therefore propagates forward. This is the defined behaviour.
- start while busy is ignored. It is not queued.

## Timing
- Reset values: busy=0, done=0, err=0, mem_we=0, mem_a=0, mem_wd=0, state=IDLE.
- Edge E0 samples start.
- COPY of N≥1 words:
  - RD in cycles 1,3,…,2N-1 and WR in cycles 2,4,…,2N.
  - Memory commits at the end of each WR cycle.
  - done=1 in cycle 2N+1.
  - busy=1 in cycles 1..2N+1.
- FILL of N≥1 words: WR in cycles 1..N, done in cycle N+1.
- count=0: done in cycle 1. Error: err in cycle 1. busy=1 in that cycle in both cases.
- A new start is accepted earliest in the cycle after done or err.
- Reset mid-operation: a write presented in the cycle where reset=1 still commits at that edge, because the memory is not reset. From the next cycle all outputs are at their reset values, no done or err is issued, and the partial transfer is abandoned.
- All outputs are decoded from registered state and pointers. The only combinational input path is mem_rd into the buf capture.

## Structure
- Package dmem_dma_pkg holds:
  - state_t enum {IDLE, RD, WR, DONE, ERR}
  - mode constants MODE_COPY=1'b0, MODE_FILL=1'b1
  - WORD_BYTES=4
- Single flat module containing the FSM, the src_ptr, dst_ptr and remaining registers, and buf. No sub-module is warranted.
- The bench instantiates the existing data memory and connects we/a/wd/rd to mem_we/mem_a/mem_wd/mem_rd.

## Test plan
- COPY: preload RAM[0..2]=0x11111111/0x22222222/0x33333333, then src=0x00, dst=0x40, count=3. Expect RAM[16..18] equal to those values, done in cycle 7, busy in cycles 1–7.
- FILL: dst=0x80, count=4, fill=0xDEADBEEF. Expect RAM[32..35]=0xDEADBEEF, done in cycle 5, and RAM[31] and RAM[36] unchanged.
- Boundaries:
  - count=0: done in cycle 1 and mem_we never high.
  - COPY with src=0x02: err in cycle 1, no write, done never high.
  - FILL with src=0x02, dst=0x00, count=1: accepted, because src is ignored in FILL.
- Overlap: RAM[0]=0xA5A5A5A5, COPY src=0x00, dst=0x04, count=3. Expect RAM[1..3]=0xA5A5A5A5.
- Reset mid-operation: FILL count=8 at 0x00 with reset high in cycle 3. Expect RAM[0..2] written, RAM[3..7] unchanged, no done, all outputs 0 from cycle 4, and a fresh start accepted afterwards.
